// File: rtl/forwarding_control_logic.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_control_logic
// Description : RV32I EX-stage operand forwarding selects and load-use stall.
//               Optional load-use stall enabled by macro FWD_LOAD_USE_STALL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_control_logic #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_instr,
    input  logic [31:0] prev_instr,
    input  logic        control_signal,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic        forward_control,
    output logic        stall
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_EX  = 2'b10;
    localparam logic [1:0] SEL_MEM = 2'b01;

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_REG, OP_IMM, OP_LOAD, OP_JALR, OP_JAL, OP_LUI, OP_AUIPC: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            OP_REG, OP_STORE, OP_BRANCH, OP_IMM, OP_LOAD, OP_JALR: uses_rs1 = 1'b1;
            default: uses_rs1 = 1'b0;
        endcase
    endfunction

    // I-type bits [24:20] are immediate, so only R/S/B formats read rs2.
    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            OP_REG, OP_STORE, OP_BRANCH: uses_rs2 = 1'b1;
            default: uses_rs2 = 1'b0;
        endcase
    endfunction

    logic [31:0] mem_instr_q, mem_instr_d;
    logic        mem_we_q, mem_we_d;

    assign mem_instr_d = prev_instr;
    assign mem_we_d    = control_signal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_instr_q <= NOP_INSTR;
            mem_we_q    <= 1'b0;
        end else begin
            mem_instr_q <= mem_instr_d;
            mem_we_q    <= mem_we_d;
        end
    end

    logic [6:0] cur_op, prev_op, mem_op;
    logic [4:0] cur_rs1, cur_rs2, prev_rd, mem_rd;
    logic       ex_valid, mem_valid;
    logic       ex_match_a, ex_match_b, mem_match_a, mem_match_b;
    logic       stall_w;

    assign cur_op  = current_instr[6:0];
    assign cur_rs1 = current_instr[19:15];
    assign cur_rs2 = current_instr[24:20];
    assign prev_op = prev_instr[6:0];
    assign prev_rd = prev_instr[11:7];
    assign mem_op  = mem_instr_q[6:0];
    assign mem_rd  = mem_instr_q[11:7];

    assign ex_valid  = control_signal && writes_rd(prev_op) && (prev_rd != 5'd0);
    assign mem_valid = mem_we_q && writes_rd(mem_op) && (mem_rd != 5'd0);

    assign ex_match_a  = ex_valid  && uses_rs1(cur_op) && (prev_rd == cur_rs1);
    assign ex_match_b  = ex_valid  && uses_rs2(cur_op) && (prev_rd == cur_rs2);
    assign mem_match_a = mem_valid && uses_rs1(cur_op) && (mem_rd  == cur_rs1);
    assign mem_match_b = mem_valid && uses_rs2(cur_op) && (mem_rd  == cur_rs2);

`ifdef FWD_LOAD_USE_STALL_EN
    assign stall_w = (prev_op == OP_LOAD) && (ex_match_a || ex_match_b);
`else
    assign stall_w = 1'b0;
`endif

    // A stalled EX match selects the register file, never the older MEM copy.
    always_comb begin
        forward_a = SEL_RF;
        forward_b = SEL_RF;
        if (ex_match_a) begin
            forward_a = stall_w ? SEL_RF : SEL_EX;
        end else if (mem_match_a) begin
            forward_a = SEL_MEM;
        end
        if (ex_match_b) begin
            forward_b = stall_w ? SEL_RF : SEL_EX;
        end else if (mem_match_b) begin
            forward_b = SEL_MEM;
        end
    end

    assign forward_control = |{forward_a, forward_b};
    assign stall           = stall_w;

endmodule
`default_nettype wire

// File: tb/tb_forwarding_control_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_forwarding_control_logic
// Description : Directed scoreboard bench for forwarding_control_logic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forwarding_control_logic;

    typedef struct {
        string      tag;
        logic [1:0] a;
        logic [1:0] b;
        logic       s;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] current_instr;
    logic [31:0] prev_instr;
    logic        control_signal;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic        forward_control;
    logic        stall;

    exp_t exp_q[$];
    int   total_checks;
    int   passed_checks;

    localparam logic [31:0] ADD_X5_X3_X4 = 32'h004182B3;
    localparam logic [31:0] ADDI_X3      = 32'h00100193;
    localparam logic [31:0] ADDI_X4      = 32'h00700213;
    localparam logic [31:0] NOP          = 32'h00000013;
    localparam logic [31:0] LW_X3        = 32'h00002183;

    forwarding_control_logic #(.NOP_INSTR(32'h00000013)) dut (
        .clk            (clk),
        .reset          (reset),
        .current_instr  (current_instr),
        .prev_instr     (prev_instr),
        .control_signal (control_signal),
        .forward_a      (forward_a),
        .forward_b      (forward_b),
        .forward_control(forward_control),
        .stall          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [31:0] cur, input logic [31:0] prv, input logic ctl,
                         input string tag, input logic [1:0] ea, input logic [1:0] eb,
                         input logic es);
        exp_t e;
        current_instr  = cur;
        prev_instr     = prv;
        control_signal = ctl;
        e.tag = tag;
        e.a   = ea;
        e.b   = eb;
        e.s   = es;
        exp_q.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic c;
        #1;
        if (exp_q.size() == 0) begin
            total_checks++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = exp_q.pop_front();
        c = |{e.a, e.b};
        total_checks++;
        assert (forward_a === e.a) passed_checks++;
        else $error("FAIL %s.forward_a observed=%b expected=%b", e.tag, forward_a, e.a);
        total_checks++;
        assert (forward_b === e.b) passed_checks++;
        else $error("FAIL %s.forward_b observed=%b expected=%b", e.tag, forward_b, e.b);
        total_checks++;
        assert (forward_control === c) passed_checks++;
        else $error("FAIL %s.forward_control observed=%b expected=%b", e.tag, forward_control, c);
        total_checks++;
        assert (stall === e.s) passed_checks++;
        else $error("FAIL %s.stall observed=%b expected=%b", e.tag, stall, e.s);
    endtask

    // Apply one step mid-cycle, check, then let the next rising edge capture prev.
    task automatic step(input logic [31:0] cur, input logic [31:0] prv, input logic ctl,
                        input string tag, input logic [1:0] ea, input logic [1:0] eb,
                        input logic es);
        drive(cur, prv, ctl, tag, ea, eb, es);
        check_out();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total_checks   = 0;
        passed_checks  = 0;
        reset          = 1'b1;
        current_instr  = 32'h0;
        prev_instr     = 32'h0;
        control_signal = 1'b0;

        drive(32'h0, 32'h0, 1'b0, "reset_idle", 2'b00, 2'b00, 1'b0);
        check_out();
        @(negedge clk);
        step(32'h00100093, 32'h00108093, 1'b1, "reset_rs1_x0", 2'b00, 2'b00, 1'b0);
        reset = 1'b0;

        step(ADD_X5_X3_X4, ADDI_X3, 1'b0, "ex_ctl0",        2'b00, 2'b00, 1'b0);
        step(ADD_X5_X3_X4, ADDI_X3, 1'b1, "ex_a",           2'b10, 2'b00, 1'b0);
        step(ADD_X5_X3_X4, ADDI_X4, 1'b1, "mem_a_ex_b",     2'b01, 2'b10, 1'b0);
        step(ADD_X5_X3_X4, NOP,     1'b1, "mem_b",          2'b00, 2'b01, 1'b0);
        step(ADD_X5_X3_X4, ADDI_X3, 1'b1, "ex_a_again",     2'b10, 2'b00, 1'b0);
        step(ADD_X5_X3_X4, ADDI_X3, 1'b1, "ex_priority",    2'b10, 2'b00, 1'b0);
        step(32'h00300313, ADDI_X3, 1'b1, "imm_not_rs2",    2'b00, 2'b00, 1'b0);
        step(32'h000002B3, 32'h00100013, 1'b1, "x0_never",  2'b00, 2'b00, 1'b0);
        step(32'h0041807F, ADDI_X3, 1'b1, "unknown_cons",   2'b00, 2'b00, 1'b0);
        step(ADD_X5_X3_X4, 32'h000001FF, 1'b1, "unknown_prod_mem_a", 2'b01, 2'b00, 1'b0);
        step(32'h0041A023, ADDI_X4, 1'b1, "store_ex_b",     2'b00, 2'b10, 1'b0);
`ifdef FWD_LOAD_USE_STALL_EN
        step(ADD_X5_X3_X4, LW_X3,  1'b1, "load_use",        2'b00, 2'b01, 1'b1);
`else
        step(ADD_X5_X3_X4, LW_X3,  1'b1, "load_use",        2'b10, 2'b01, 1'b0);
`endif
        // MEM copy now holds LW x3 with valid set; async reset must drop it at once.
        #2;
        reset = 1'b1;
        drive(ADD_X5_X3_X4, NOP, 1'b1, "async_reset_mem", 2'b00, 2'b00, 1'b0);
        check_out();
        reset = 1'b0;

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

    initial begin
        #100000;
        $error("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
